// File: rtl/shift_reg_pkg.sv
// Purpose: shared mode encodings and helpers for the universal shift register.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROTL = 3'd4;
    localparam logic [2:0] MODE_ROTR = 3'd5;
    // Encodings 6 and 7 are reserved and act as HOLD.

    // True for every mode that moves bits and therefore advances the frame count.
    function automatic logic is_shift(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Purpose: counts shifts modulo WIDTH and pulses done for one cycle when a frame completes.
// Latency: done is registered, high in the cycle right after the WIDTH-th shift edge.
// Backpressure: none; caller gates inc/clr with its own enable.
//
// Ports:
//   clk   - clock, all state updates on rising edge
//   reset - synchronous active-high reset (clears count and done)
//   clr   - clear the partial count (used on parallel load)
//   inc   - one shift happened this cycle
//   done  - single-cycle frame completion pulse
module shift_frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            // done is rewritten every cycle so it can never stretch past one clock.
            done <= inc && !clr && at_last;
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                // Explicit wrap so non-power-of-two widths still frame at WIDTH shifts.
                cnt <= at_last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Purpose: universal shift register (hold/load/shift/rotate) with shift-frame completion pulse.
// Latency: one clock from inputs sampled to q; serial outputs combinational from q.
// Backpressure: none; en=0 freezes all state including the partial frame count.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   en                    - clock enable
//   mode                  - operation select (see shift_reg_pkg)
//   d                     - parallel load data
//   ser_in_r / ser_in_l   - serial input for left shifts (enters bit 0) / right shifts (enters MSB)
//   q                     - register contents
//   ser_out_l / ser_out_r - q MSB / q LSB
//   frame_done            - one-cycle pulse after every WIDTH shifts
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             frame_done
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("univ_shift_reg: WIDTH must be in 2..64");
        end
    endgenerate

    logic [WIDTH-1:0] q_nxt;
    logic             cnt_inc;
    logic             cnt_clr;

    always_comb begin
        q_nxt = q;
        unique case (mode)
            MODE_LOAD: q_nxt = d;
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  q_nxt = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
            default:   q_nxt = q;   // HOLD and reserved encodings
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= q_nxt;
        end
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

    assign cnt_inc = en && is_shift(mode);
    assign cnt_clr = en && (mode == MODE_LOAD);

    shift_frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .done  (frame_done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Purpose: self-checking bench for univ_shift_reg (WIDTH=8), directed scenarios plus random traffic.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_univ_shift_reg;
    import shift_reg_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] q;
    logic         ser_out_l;
    logic         ser_out_r;
    logic         frame_done;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .d          (d),
        .ser_in_r   (ser_in_r),
        .ser_in_l   (ser_in_l),
        .q          (q),
        .ser_out_l  (ser_out_l),
        .ser_out_r  (ser_out_r),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: register value as an integer, shifts counted since last frame boundary.
    int mq        = 0;
    int shifts    = 0;
    bit exp_done  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare every output.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] dd, input logic sl, input logic sr);
        reset    = r;
        en       = e;
        mode     = m;
        d        = dd;
        ser_in_l = sl;
        ser_in_r = sr;
        @(posedge clk);
        exp_done = 1'b0;
        if (r) begin
            mq     = 0;
            shifts = 0;
        end else if (e) begin
            case (m)
                MODE_LOAD: begin mq = int'(dd); shifts = 0; end
                MODE_SHL:  mq = ((mq * 2) % 256) + int'(sr);
                MODE_SHR:  mq = (mq / 2) + (sl ? 128 : 0);
                MODE_ROTL: mq = ((mq * 2) % 256) + (mq / 128);
                MODE_ROTR: mq = (mq / 2) + ((mq % 2) * 128);
                default:   ;
            endcase
            if (m >= MODE_SHL && m <= MODE_ROTR) begin
                shifts++;
                if (shifts == W) begin
                    exp_done = 1'b1;
                    shifts   = 0;
                end
            end
        end
        #1;
        check("q",          64'(q),          64'(mq));
        check("ser_out_l",  64'(ser_out_l),  64'(mq / 128));
        check("ser_out_r",  64'(ser_out_r),  64'(mq % 2));
        check("frame_done", 64'(frame_done), 64'(exp_done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
        @(negedge clk);

        // Reset wins over an enabled LOAD.
        step(1, 1, MODE_LOAD, 8'hFF, 0, 0);
        check("rst_q",  64'(q), 64'h00);
        check("rst_fd", 64'(frame_done), 64'd0);

        // LOAD then shift left with a 1 entering bit 0.
        step(0, 1, MODE_LOAD, 8'hA5, 0, 0);
        step(0, 1, MODE_SHL,  8'h00, 0, 1);
        check("shl_q",   64'(q), 64'h4B);
        check("shl_sol", 64'(ser_out_l), 64'd0);
        check("shl_sor", 64'(ser_out_r), 64'd1);

        // Rotations.
        step(0, 1, MODE_LOAD, 8'h81, 0, 0);
        step(0, 1, MODE_ROTR, 8'h00, 0, 0);
        check("rotr_q", 64'(q), 64'hC0);
        step(0, 1, MODE_ROTL, 8'h00, 0, 0);
        step(0, 1, MODE_ROTL, 8'h00, 0, 0);
        check("rotl_q", 64'(q), 64'h03);

        // Eight right shifts filling with ones; pulse only after the eighth.
        step(0, 1, MODE_LOAD, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, MODE_SHR, 8'h00, 1, 0);
            check("shr_fd", 64'(frame_done), (i == 7) ? 64'd1 : 64'd0);
        end
        check("shr8_q", 64'(q), 64'hFF);
        step(0, 1, MODE_HOLD, 8'h00, 0, 0);
        check("shr_fd_drop", 64'(frame_done), 64'd0);

        // Frame survives en=0 gaps; reserved mode is a hold.
        step(0, 1, MODE_LOAD, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, MODE_SHL, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, MODE_SHR, 8'hFF, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, (i % 2 == 0) ? MODE_ROTL : MODE_SHR, 8'h00, 0, 0);
            check("gap_fd", 64'(frame_done), (i == 4) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 3'd6, 8'h5A, 1, 1);
            check("rsvd_fd", 64'(frame_done), 64'd0);
        end

        // Reset mid-frame discards the partial count.
        step(0, 1, MODE_LOAD, 8'h12, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, MODE_SHL, 8'h00, 0, 0);
        step(1, 0, MODE_HOLD, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, MODE_ROTR, 8'h00, 0, 0);
            check("rst7_fd", 64'(frame_done), 64'd0);
        end
        step(0, 1, MODE_SHL, 8'h00, 0, 1);
        check("rst8_fd", 64'(frame_done), 64'd1);

        // Random traffic across all encodings including reserved ones.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
